sx3_i2c_ctrl_slave: RTL
=======================

SX3_I2C_CTRL_SLAVE -- requirements
Module: sx3_i2c_ctrl_slave

Interface
REQ-001 SHALL provide parameter I2C_ADDR, default 7'h4C, the 7-bit responder address.
REQ-002 SHALL provide parameter DEV_ID, default 8'hA5, the read-only ID returned at register 0x0F.
REQ-003 SHALL provide port clk_osc, input, 1 bit: 48 MHz internal oscillator clock.
REQ-004 SHALL provide port reset_n_HFCLKOUT, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL provide port scl_i, input, 1 bit: raw SX3 I2C clock.
REQ-006 SHALL provide port sda_i, input, 1 bit: raw SDA pad value.
REQ-007 SHALL provide port sda_oe_o, output, 1 bit: 1 means pull SDA low; 0 means release the line.
REQ-008 SHALL provide port cam_fifo_overflow_i, input, 1 bit: overflow pulse, already in the clk_osc domain.
REQ-009 SHALL provide ports cam_app_en_o, aud_app_en_o and still_cap_en_o, output, 1 bit each: levels taken from the CTRL register.
REQ-010 SHALL provide ports vid_skt_rst_o and aud_skt_rst_o, output, 1 bit each: one-cycle socket-reset pulses.
REQ-011 SHALL provide ports img_width_o, img_height_o and line_blanking_o, output, 16 bits each.
REQ-012 SHALL provide port vid_fps_o, output, 8 bits.
REQ-013 SHALL provide port busy_o, output, 1 bit: high from START to STOP when this device is addressed.

Function
REQ-014 SHALL pass scl_i and sda_i through a 2-FF synchronizer, then a filter that accepts a new level only after 3 identical consecutive samples.
REQ-015 SHALL detect START as filtered SDA falling while filtered SCL is high, and STOP as filtered SDA rising while filtered SCL is high.
REQ-016 SHALL sample SDA on the filtered SCL rising edge and change sda_oe_o only on the filtered SCL falling edge, with at most 6 clk_osc cycles from the raw SCL fall.
REQ-017 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA and RDATA_ACK.
REQ-018 SHALL, on START from any state, clear the bit counter and go to ADDR; a repeated START is handled the same way.
REQ-019 SHALL, on STOP from any state, go to IDLE, release SDA and deassert busy_o.
REQ-020 SHALL, in ADDR, shift in 8 bits MSB first; on address match it ACKs and continues, R/W=0 to REG and R/W=1 to RDATA.
REQ-021 SHALL, on address mismatch, return to IDLE without driving SDA.
REQ-022 SHALL, in REG, load the 8-bit register pointer, ACK it, and then go to WDATA.
REQ-023 SHALL ACK every WDATA byte, write it to the register at the pointer, and then increment the pointer (8-bit wrap, 0xFF to 0x00).
REQ-024 SHALL, in RDATA, load the shift register at the address-ACK or master-ACK falling edge, drive bits MSB first (sda_oe_o = ~bit), and increment the pointer after each byte.
REQ-025 SHALL, on master NACK in RDATA_ACK, release SDA and wait in IDLE for STOP or START.
REQ-026 SHALL use register map 0x00 CTRL: bit0 cam_app_en, bit1 aud_app_en, bit2 still_cap_en, bit3 vid_skt_rst, bit4 aud_skt_rst.
REQ-027 SHALL use register map 0x01/0x02 img_width lo/hi, 0x03/0x04 img_height lo/hi, 0x05 vid_fps, 0x06/0x07 line_blanking lo/hi.
REQ-028 SHALL use register map 0x08 STATUS (bit0 sticky overflow) and 0x0F ID.
REQ-029 SHALL, when a 1 is written to CTRL bit3 or bit4, pulse the matching *_skt_rst_o high for exactly 1 clk_osc cycle; these bits always read 0.
REQ-030 SHALL hold a low-byte write to a 16-bit register in a shadow register, and update both bytes of the output atomically on the high-byte write.
REQ-031 SHALL return the committed value, not the shadow, when a low byte is read.
REQ-032 SHALL set STATUS bit0 on cam_fifo_overflow_i and clear it on any write to 0x08.
REQ-033 SHALL keep STATUS bit0 at 1 when a set and a clearing write occur in the same cycle.
REQ-034 SHALL ACK writes to unmapped and read-only addresses and discard the data.
REQ-035 SHALL return 0x00 for reads of unmapped addresses.
REQ-036 SHALL register all outputs, with no combinational path from the pins to the outputs.

Reset
REQ-037 SHALL, while reset_n_HFCLKOUT is low, put the FSM in IDLE and drive sda_oe_o=0, busy_o=0 and all enables and socket-reset pulses to 0.
REQ-038 SHALL reset img_width_o to 16'd1920, img_height_o to 16'd1280, vid_fps_o to 8'd30, line_blanking_o to 0, the pointer to 0, the shadow registers to 0 and STATUS to 0.
REQ-039 SHALL, when reset asserts mid-transfer, release SDA immediately, and SHALL ignore bus activity until the next valid START.

Verification
REQ-040 SHALL cover: write 0x4C-W, reg 0x01, data 0x00, 0x0A -> every byte ACKed, img_width_o 1920 until the 0x0A ACK, then 16'h0A00 in one step.
REQ-041 SHALL cover: write reg 0x00 with 0x19 -> cam_app_en_o=1, still_cap_en_o=0, vid_skt_rst_o high for exactly 1 cycle, and a readback of 0x00 returns 0x01.
REQ-042 SHALL cover: write reg 0x0E, then repeated START, 0x4C-R, read 3 bytes with ACK, ACK, NACK -> returns 0x00, 0xA5, 0x00, with pointer wrap checked separately from 0xFF.
REQ-043 SHALL cover: address 0x4D -> SDA never driven and no register changes.
REQ-044 SHALL cover: cam_fifo_overflow_i pulse -> STATUS reads 0x01; write 0x08 -> reads 0x00; set during the clearing write -> stays 0x01.
REQ-045 SHALL cover: assert reset during a data byte and inject 1-2-cycle SCL/SDA glitches -> sda_oe_o=0 at once, default registers, glitches ignored.

Source files
------------

// File: rtl/sx3_i2c_ctrl_slave.sv
// I2C responder for SX3 camera/audio control: filtered bus front-end, byte FSM,
// and the control/format register bank driven by the interface.
`timescale 1ns/1ps
module sx3_i2c_ctrl_slave #(
    parameter logic [6:0] I2C_ADDR = 7'h4C,
    parameter logic [7:0] DEV_ID   = 8'hA5
) (
    input  logic        clk_osc,
    input  logic        reset_n_HFCLKOUT,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic        cam_fifo_overflow_i,
    output logic        cam_app_en_o,
    output logic        aud_app_en_o,
    output logic        still_cap_en_o,
    output logic        vid_skt_rst_o,
    output logic        aud_skt_rst_o,
    output logic [15:0] img_width_o,
    output logic [15:0] img_height_o,
    output logic [15:0] line_blanking_o,
    output logic [7:0]  vid_fps_o,
    output logic        busy_o
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    logic [1:0] scl_sync_q, sda_sync_q, scl_hist_q, sda_hist_q;
    logic       scl_f_q, sda_f_q, scl_f_d, sda_f_d;
    logic       armed_q;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       mack_q, mack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_en;
    logic [7:0] rdata;

    logic [2:0]  ctrl_q;
    logic        vid_rst_q, aud_rst_q;
    logic [15:0] width_q, height_q, blank_q;
    logic [7:0]  fps_q, wlo_q, hlo_q, blo_q;
    logic        status_q;

    // Window is {two history samples, newest synchronized sample}: a level is
    // accepted on its third consecutive sample, so SCL fall reaches the FSM 5 cycles after the pin.
    always_comb begin
        scl_f_d = scl_f_q;
        sda_f_d = sda_f_q;
        if ({scl_hist_q, scl_sync_q[1]} == 3'b111) scl_f_d = 1'b1;
        else if ({scl_hist_q, scl_sync_q[1]} == 3'b000) scl_f_d = 1'b0;
        if ({sda_hist_q, sda_sync_q[1]} == 3'b111) sda_f_d = 1'b1;
        else if ({sda_hist_q, sda_sync_q[1]} == 3'b000) sda_f_d = 1'b0;
    end

    assign scl_rise  = ~scl_f_q & scl_f_d;
    assign scl_fall  = scl_f_q & ~scl_f_d;
    // START only counts once the bus has been seen idle-high since reset.
    assign start_det = armed_q & scl_f_q & scl_f_d & sda_f_q & ~sda_f_d;
    assign stop_det  = scl_f_q & scl_f_d & ~sda_f_q & sda_f_d;

    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            scl_hist_q <= '0;
            sda_hist_q <= '0;
            scl_f_q    <= 1'b0;
            sda_f_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            armed_q    <= armed_q | (scl_f_q & sda_f_q);
        end
    end

    always_comb begin
        case (ptr_q)
            8'h00:   rdata = {5'b0, ctrl_q};
            8'h01:   rdata = width_q[7:0];
            8'h02:   rdata = width_q[15:8];
            8'h03:   rdata = height_q[7:0];
            8'h04:   rdata = height_q[15:8];
            8'h05:   rdata = fps_q;
            8'h06:   rdata = blank_q[7:0];
            8'h07:   rdata = blank_q[15:8];
            8'h08:   rdata = {7'b0, status_q};
            8'h0F:   rdata = DEV_ID;
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        mack_d   = mack_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        wr_en    = 1'b0;
        if (start_det) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    shift_d  = {shift_q[6:0], sda_f_q};
                    bitcnt_d = bitcnt_q + 4'd1;
                end
                ST_RDATA:     bitcnt_d = bitcnt_q + 4'd1;
                ST_RDATA_ACK: mack_d = ~sda_f_q;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR: if (bitcnt_q == 4'd8) begin
                    if (shift_q[7:1] == I2C_ADDR) begin
                        state_d  = ST_ADDR_ACK;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_ADDR_ACK: begin
                    bitcnt_d = '0;
                    if (shift_q[0]) begin
                        shift_d  = rdata;
                        sda_oe_d = ~rdata[7];
                        state_d  = ST_RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_REG;
                    end
                end
                ST_REG: if (bitcnt_q == 4'd8) begin
                    ptr_d    = shift_q;
                    sda_oe_d = 1'b1;
                    state_d  = ST_REG_ACK;
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    sda_oe_d = 1'b0;
                    bitcnt_d = '0;
                    state_d  = ST_WDATA;
                end
                ST_WDATA: if (bitcnt_q == 4'd8) begin
                    wr_en    = 1'b1;
                    ptr_d    = ptr_q + 8'd1;
                    sda_oe_d = 1'b1;
                    state_d  = ST_WDATA_ACK;
                end
                ST_RDATA: begin
                    if (bitcnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        ptr_d    = ptr_q + 8'd1;
                        state_d  = ST_RDATA_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RDATA_ACK: begin
                    if (mack_q) begin
                        shift_d  = rdata;
                        sda_oe_d = ~rdata[7];
                        bitcnt_d = '0;
                        state_d  = ST_RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            mack_q   <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            mack_q   <= mack_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
        end
    end

    // Low bytes of 16-bit fields park in a shadow until the high byte commits both.
    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) begin
            ctrl_q    <= '0;
            vid_rst_q <= 1'b0;
            aud_rst_q <= 1'b0;
            width_q   <= 16'd1920;
            height_q  <= 16'd1280;
            fps_q     <= 8'd30;
            blank_q   <= '0;
            wlo_q     <= '0;
            hlo_q     <= '0;
            blo_q     <= '0;
            status_q  <= 1'b0;
        end else begin
            vid_rst_q <= wr_en && (ptr_q == 8'h00) && shift_q[3];
            aud_rst_q <= wr_en && (ptr_q == 8'h00) && shift_q[4];
            status_q  <= cam_fifo_overflow_i | (status_q & ~(wr_en && (ptr_q == 8'h08)));
            if (wr_en) begin
                case (ptr_q)
                    8'h00: ctrl_q   <= shift_q[2:0];
                    8'h01: wlo_q    <= shift_q;
                    8'h02: width_q  <= {shift_q, wlo_q};
                    8'h03: hlo_q    <= shift_q;
                    8'h04: height_q <= {shift_q, hlo_q};
                    8'h05: fps_q    <= shift_q;
                    8'h06: blo_q    <= shift_q;
                    8'h07: blank_q  <= {shift_q, blo_q};
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe_o        = sda_oe_q;
    assign busy_o          = busy_q;
    assign cam_app_en_o    = ctrl_q[0];
    assign aud_app_en_o    = ctrl_q[1];
    assign still_cap_en_o  = ctrl_q[2];
    assign vid_skt_rst_o   = vid_rst_q;
    assign aud_skt_rst_o   = aud_rst_q;
    assign img_width_o     = width_q;
    assign img_height_o    = height_q;
    assign line_blanking_o = blank_q;
    assign vid_fps_o       = fps_q;

endmodule
